// File: rtl/spi_ram_slave_sync.sv
// spi_ram_slave_sync: SPI mode-0 byte-addressed RAM target oversampled on the system clock
`timescale 1ns/1ps
module spi_ram_slave_sync #(
  parameter int MEM_AW      = 11,
  parameter int CMD_AW      = 24,
  parameter int DUMMY_BITS  = 8,
  parameter int SYNC_STAGES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  input  logic spi_mosi,
  input  logic spi_select,
  output logic spi_miso,
  output logic spi_miso_oe,
  input  logic clear_err,
  output logic cur_err,
  output logic ind_err,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, STATUS, ERR} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] clk_sr, mosi_sr, sel_sr;
  logic sclk, mosi_s, sel_s, clk_q, armed, rise, fall, out_ok;
  logic [7:0] cnt, sh, op, rdata, osh, din, src;
  logic [2:0] ocnt;
  logic [MEM_AW-1:0] addr;
  logic wr_pend, fetch, miso_q, oe_q, ind_q, cur_q;
  logic [7:0] mem [0:(1<<MEM_AW)-1];
  assign sclk   = clk_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign sel_s  = sel_sr[SYNC_STAGES-1];
  assign rise   = sclk & ~clk_q;
  assign fall   = ~sclk & clk_q;
  assign din    = {sh[6:0], mosi_s};
  assign out_ok = nxt == READ || nxt == STATUS;
  assign src    = state == STATUS ? {6'b0, ind_q, cur_q} : rdata;
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  // next state: deselect overrides everything, decode happens on the completing rise
  always_comb begin
    nxt = state;
    if (sel_s) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = armed ? CMD : IDLE;
        CMD:     if (rise && cnt == 8'd7)
                   nxt = (din == 8'h03 || din == 8'h0B || din == 8'h02) ? ADDR :
                         din == 8'h05 ? STATUS : ERR;
        ADDR:    if (rise && cnt == 8'(CMD_AW-1))
                   nxt = op == 8'h0B ? DUMMY : op == 8'h02 ? WRITE : READ;
        DUMMY:   if (rise && cnt == 8'(DUMMY_BITS-1)) nxt = READ;
        default: nxt = state;
      endcase
  end
  // outputs decoded from state and the registered MISO path
  always_comb begin
    busy        = !(state == IDLE || state == ERR);
    cur_err     = state == ERR;
    ind_err     = ind_q;
    spi_miso_oe = oe_q;
    spi_miso    = miso_q & oe_q;
  end
  // synchronisers, bit counters, address and MISO shifter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sr  <= '0;
      mosi_sr <= '0;
      sel_sr  <= '0;
      clk_q   <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      op      <= '0;
      addr    <= '0;
      wr_pend <= 1'b0;
      fetch   <= 1'b0;
      ocnt    <= '0;
      osh     <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      ind_q   <= 1'b0;
      cur_q   <= 1'b0;
    end else begin
      clk_sr  <= {clk_sr[SYNC_STAGES-2:0], spi_clk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sel_sr  <= {sel_sr[SYNC_STAGES-2:0], spi_select};
      clk_q   <= sclk;
      armed   <= armed | sel_s;
      cnt     <= nxt != state ? '0 : cnt + 8'(rise);
      sh      <= rise ? din : sh;
      op      <= state == CMD && rise ? din : op;
      addr    <= state == ADDR && rise ? {addr[MEM_AW-2:0], mosi_s} :
                 (wr_pend || fetch) ? addr + 1'b1 : addr;
      wr_pend <= state == WRITE && nxt == WRITE && rise && cnt[2:0] == 3'd7;
      fetch   <= nxt == READ && (state != READ || (fall && ocnt == 3'd0));
      ocnt    <= !out_ok ? 3'd0 : ocnt + 3'(fall);
      miso_q  <= !out_ok ? 1'b0 : !fall ? miso_q : ocnt == 3'd0 ? src[7] : osh[7];
      osh     <= !fall ? osh : ocnt == 3'd0 ? {src[6:0], 1'b0} : {osh[6:0], 1'b0};
      oe_q    <= out_ok && (oe_q || fall);
      ind_q   <= state == ERR || (ind_q && clear_err);
      cur_q   <= state == ERR;
    end
  end
  // memory: one-clock write commit and registered read fetch, contents never reset
  always_ff @(posedge clk) begin
    if (wr_pend && rst_n) mem[addr] <= sh;
    if (fetch) rdata <= mem[addr];
  end
endmodule
